// File: rtl/video_timing_gen_if.sv
// Bundle of control inputs and timing outputs for video_timing_gen.
// The slave side is the timing generator; the master side drives en/resync.
interface video_timing_gen_if #(
    parameter int CW = 12,
    parameter int FW = 8
);
    logic          en;
    logic          resync;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          sof;
    logic          eol;
    logic [FW-1:0] frame_cnt;

    modport master (
        output en, resync,
        input  x, y, hsync, vsync, de, sof, eol, frame_cnt
    );

    modport slave (
        input  en, resync,
        output x, y, hsync, vsync, de, sof, eol, frame_cnt
    );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: horizontal/vertical counters with registered
// sync, data-enable, coordinate and frame markers, one cycle behind the counters.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 12,
    parameter int FW       = 8
) (
    input  logic              clk,
    input  logic              reset,
    video_timing_gen_if.slave bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_EOL  = CW'(H_ACTIVE - 1);
    // Region bounds carry one extra bit so an end equal to 2^CW still compares correctly.
    localparam logic [CW:0]   H_ACT  = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0]   V_ACT  = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0]   HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0]   HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0]   VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0]   VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
    logic [FW-1:0] fcnt_q, fcnt_d, fcnt_out_q, fcnt_out_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    logic          de_q, de_d, sof_q, sof_d, eol_q, eol_d;
    logic [CW:0]   hc_ext_s, vc_ext_s;
    logic          active_s;

    assign hc_ext_s = {1'b0, hc_q};
    assign vc_ext_s = {1'b0, vc_q};
    assign active_s = (hc_ext_s < H_ACT) && (vc_ext_s < V_ACT);

    // Next counter position and completed-frame count.
    always_comb begin
        hc_d   = hc_q;
        vc_d   = vc_q;
        fcnt_d = fcnt_q;
        if (bus.resync) begin
            hc_d = '0;
            vc_d = '0;
        end else if (bus.en) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                if (vc_q == V_LAST) begin
                    vc_d   = '0;
                    fcnt_d = fcnt_q + FW'(1);
                end else begin
                    vc_d = vc_q + CW'(1);
                end
            end else begin
                hc_d = hc_q + CW'(1);
            end
        end else begin
            hc_d   = hc_q;
            vc_d   = vc_q;
            fcnt_d = fcnt_q;
        end
    end

    // Output values decoded from the current position; markers drop while paused.
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        de_d       = 1'b0;
        sof_d      = 1'b0;
        eol_d      = 1'b0;
        fcnt_out_d = fcnt_q;
        if (bus.en) begin
            de_d    = active_s;
            x_d     = active_s ? hc_q : '0;
            y_d     = active_s ? vc_q : '0;
            hsync_d = ((hc_ext_s >= HS_BEG) && (hc_ext_s < HS_END)) ? HS_POL : ~HS_POL;
            vsync_d = ((vc_ext_s >= VS_BEG) && (vc_ext_s < VS_END)) ? VS_POL : ~VS_POL;
            sof_d   = (hc_q == '0) && (vc_q == '0);
            eol_d   = (hc_q == H_EOL) && (vc_ext_s < V_ACT);
        end else begin
            de_d  = 1'b0;
            sof_d = 1'b0;
            eol_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            hc_q       <= '0;
            vc_q       <= '0;
            fcnt_q     <= '0;
            fcnt_out_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            hsync_q    <= ~HS_POL;
            vsync_q    <= ~VS_POL;
            de_q       <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
        end else begin
            hc_q       <= hc_d;
            vc_q       <= vc_d;
            fcnt_q     <= fcnt_d;
            fcnt_out_q <= fcnt_out_d;
            x_q        <= x_d;
            y_q        <= y_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            de_q       <= de_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
        end
    end

    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.hsync     = hsync_q;
    assign bus.vsync     = vsync_q;
    assign bus.de        = de_q;
    assign bus.sof       = sof_q;
    assign bus.eol       = eol_q;
    assign bus.frame_cnt = fcnt_out_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen with a small raster (7x6 clocks per frame, FW=2),
// using a frame-position reference model, a vector table and corner sequences.
module tb_video_timing_gen;
    localparam int HA = 4, HFP = 1, HS = 1, HBP = 1;
    localparam int VA = 3, VFP = 1, VS = 1, VBP = 1;
    localparam bit HS_POL = 1'b1, VS_POL = 1'b0;
    localparam int CW = 8, FW = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    video_timing_gen_if #(.CW(CW), .FW(FW)) bus ();

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW), .FW(FW)
    ) dut (
        .clk(clk),
        .reset(rst),
        .bus(bus)
    );

    typedef struct {
        logic r, e, s;
        int   x, y;
        logic hs, vs, de, sof, eol;
        int   fc;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    // Reference model: linear position within the frame plus completed frames.
    int   m_pos = 0, m_frames = 0;
    int   ex = 0, ey = 0, efc = 0;
    logic ehs = ~HS_POL, evs = ~VS_POL, ede = 1'b0, esof = 1'b0, eeol = 1'b0;

    function automatic logic [22:0] pk(input int x, input int y, input logic hs, input logic vs,
                                       input logic de, input logic sof, input logic eol, input int fc);
        logic [7:0] xb, yb;
        logic [1:0] fb;
        xb = x[7:0];
        yb = y[7:0];
        fb = fc[1:0];
        return {xb, yb, hs, vs, de, sof, eol, fb};
    endfunction

    function automatic logic [22:0] dut_pk();
        return pk(int'(bus.x), int'(bus.y), bus.hsync, bus.vsync, bus.de, bus.sof, bus.eol,
                  int'(bus.frame_cnt));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic s);
        int h, v;
        rst        = r;
        bus.en     = e;
        bus.resync = s;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_pos = 0; m_frames = 0;
            ex = 0; ey = 0; efc = 0;
            ehs = ~HS_POL; evs = ~VS_POL; ede = 1'b0; esof = 1'b0; eeol = 1'b0;
        end else begin
            h = m_pos % HT;
            v = m_pos / HT;
            if (e) begin
                ede  = (h < HA) && (v < VA);
                ex   = ede ? h : 0;
                ey   = ede ? v : 0;
                ehs  = (h >= HA + HFP && h < HA + HFP + HS) ? HS_POL : ~HS_POL;
                evs  = (v >= VA + VFP && v < VA + VFP + VS) ? VS_POL : ~VS_POL;
                esof = (m_pos == 0);
                eeol = (h == HA - 1) && (v < VA);
            end else begin
                ede = 1'b0; esof = 1'b0; eeol = 1'b0;
            end
            efc = m_frames;
            if (s) m_pos = 0;
            else if (e) begin
                if (m_pos == FT - 1) begin
                    m_pos = 0;
                    m_frames = (m_frames + 1) % (1 << FW);
                end else m_pos++;
            end
        end
        #1;
    endtask

    task automatic step_chk(input logic r, input logic e, input logic s);
        step(r, e, s);
        chk("model", 32'(dut_pk()), 32'(pk(ex, ey, ehs, evs, ede, esof, eeol, efc)));
    endtask

    vec_t tbl[14];
    int   sof_fc[$];
    int   sof_cyc[$];
    int   t0, found;

    initial begin
        bus.en = 1'b0;
        bus.resync = 1'b0;
        //        r     e     s     x  y  hs    vs    de    sof   eol   fc
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 2, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 3, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 3, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 0, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0};

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].s);
            chk($sformatf("vec[%0d]", i), 32'(dut_pk()),
                32'(pk(tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs, tbl[i].de,
                       tbl[i].sof, tbl[i].eol, tbl[i].fc)));
        end

        // Five frames with FW=2: frame_cnt at successive sof reads 0,1,2,3,0,1.
        step_chk(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5 * FT + 2; i++) begin
            step_chk(1'b0, 1'b1, 1'b0);
            if (bus.sof) begin
                sof_fc.push_back(int'(bus.frame_cnt));
                sof_cyc.push_back(cyc);
            end
        end
        chk("sof_count", 32'(sof_fc.size()), 32'd6);
        for (int i = 0; i < sof_fc.size() && i < 6; i++) begin
            chk($sformatf("fc_at_sof[%0d]", i), 32'(sof_fc[i]), 32'((i) % 4));
            if (i > 0) chk($sformatf("sof_period[%0d]", i), 32'(sof_cyc[i] - sof_cyc[i-1]), 32'(FT));
        end

        // Pause for 37 cycles at x=2,y=1; x holds, then resumes at 3; frame stretches by 37.
        step_chk(1'b1, 1'b0, 1'b0);
        step_chk(1'b0, 1'b1, 1'b0);
        chk("sof_after_reset", 32'(bus.sof), 32'd1);
        t0 = cyc;
        found = 0;
        for (int i = 0; i < 3 * FT && found == 0; i++) begin
            step_chk(1'b0, 1'b1, 1'b0);
            if (bus.de && bus.x == 8'd2 && bus.y == 8'd1) found = 1;
        end
        chk("reach_x2_y1", 32'(found), 32'd1);
        for (int i = 0; i < 37; i++) begin
            step_chk(1'b0, 1'b0, 1'b0);
            if (i == 36) begin
                chk("pause_de", 32'(bus.de), 32'd0);
                chk("pause_x", 32'(bus.x), 32'd2);
            end
        end
        step_chk(1'b0, 1'b1, 1'b0);
        chk("resume_x", 32'(bus.x), 32'd3);
        found = 0;
        for (int i = 0; i < 3 * FT && found == 0; i++) begin
            step_chk(1'b0, 1'b1, 1'b0);
            if (bus.sof) found = 1;
        end
        chk("stretched_period", 32'(cyc - t0), 32'(FT + 37));

        // Resync on the last cycle of the frame must not count a frame.
        step_chk(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2 * FT && m_pos != FT - 1; i++) step_chk(1'b0, 1'b1, 1'b0);
        step_chk(1'b0, 1'b1, 1'b1);
        step_chk(1'b0, 1'b1, 1'b0);
        chk("resync_last_sof", 32'(bus.sof), 32'd1);
        chk("resync_last_fc", 32'(bus.frame_cnt), 32'd0);

        // Reset mid-frame overrides en and resync within one edge.
        for (int i = 0; i < 2 * FT + 26; i++) step_chk(1'b0, 1'b1, 1'b0);
        step_chk(1'b1, 1'b1, 1'b1);
        chk("midframe_reset", 32'(dut_pk()), 32'(pk(0, 0, ~HS_POL, ~VS_POL, 1'b0, 1'b0, 1'b0, 0)));

        // Randomised en/resync/reset traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            step_chk(($urandom % 300) == 0, ($urandom % 6) != 0, ($urandom % 80) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, SHALL set the active pixels per line.
REQ-002 Parameter H_FP, default 16, SHALL set the horizontal front-porch length in clocks.
REQ-003 Parameter H_SYNC, default 96, SHALL set the horizontal sync-pulse length in clocks.
REQ-004 Parameter H_BP, default 48, SHALL set the horizontal back-porch length in clocks.
REQ-005 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, SHALL set the vertical equivalents in lines.
REQ-006 Parameters HS_POL/VS_POL, default 0/0, SHALL set the sync level while in the pulse (0 = active-low); the inactive level is the inverse.
REQ-007 Parameter CW, default 12, SHALL set the counter and coordinate width; H_TOTAL and V_TOTAL SHALL each be at most 2^CW.
REQ-008 Parameter FW, default 8, SHALL set the frame-counter width.
REQ-009 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-010 Port reset, input, 1 bit: synchronous active-high reset.
REQ-011 Port en, input, 1 bit: advances the timing when high.
REQ-012 Port resync, input, 1 bit: a one-cycle pulse that restarts the frame (genlock).
REQ-013 Ports x and y, output, CW bits each: the active-area pixel coordinates.
REQ-014 Ports hsync and vsync, output, 1 bit each: the sync outputs.
REQ-015 Port de, output, 1 bit: data enable.
REQ-016 Port sof, output, 1 bit: start-of-frame pulse.
REQ-017 Port eol, output, 1 bit: end-of-active-line pulse.
REQ-018 Port frame_cnt, output, FW bits: completed-frame count.

Function
REQ-019 The internal counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1) SHALL advance as follows when en=1: hc increments each cycle; at hc=H_TOTAL-1, hc wraps to 0 and vc increments; at vc=V_TOTAL-1, vc also wraps to 0.
REQ-020 Every output SHALL be registered and SHALL reflect the counter values of the previous cycle, giving exactly 1 cycle of latency, with all outputs mutually aligned.
REQ-021 de SHALL be 1 iff hc<H_ACTIVE and vc<V_ACTIVE.
REQ-022 x and y SHALL equal hc and vc when de=1, and SHALL be 0 otherwise.
REQ-023 hsync SHALL be at level HS_POL iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, on every line including blanking lines.
REQ-024 vsync SHALL be at level VS_POL iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC; it SHALL change on the same cycle hc wraps to 0, i.e. aligned to the line start.
REQ-025 sof SHALL be 1 for exactly one cycle, when hc=0 and vc=0.
REQ-026 eol SHALL be 1 for exactly one cycle, when hc=H_ACTIVE-1 and vc<V_ACTIVE.
REQ-027 frame_cnt SHALL increment, modulo 2^FW, on the cycle where hc=H_TOTAL-1 and vc=V_TOTAL-1 with en=1; it SHALL wrap from 2^FW-1 to 0 silently.
REQ-028 While en=0, the counters and frame_cnt SHALL hold; de, sof and eol SHALL be 0; x, y, hsync and vsync SHALL hold their last values.
REQ-029 When resync=1, the next-cycle counters SHALL be hc=0 and vc=0 regardless of en or position, and frame_cnt SHALL NOT increment; output reflecting (0,0) follows one cycle later per REQ-020.
REQ-030 A resync on the cycle where hc=H_TOTAL-1 and vc=V_TOTAL-1 SHALL produce no frame_cnt increment.
REQ-031 The block SHALL be purely synchronous: no latches, and no combinational paths from any input to any output.

Reset
REQ-032 While reset=1 at a clock edge, hc, vc, x, y and frame_cnt SHALL clear to 0; de, sof and eol SHALL be 0; hsync SHALL be ~HS_POL and vsync SHALL be ~VS_POL.
REQ-033 Reset SHALL take priority over resync and en.
REQ-034 Reset asserted mid-frame SHALL take effect at the next edge.
REQ-035 On the first en=1 cycle after reset is released, the counters SHALL be at (0,0); the following cycle SHALL show sof=1, de=1, x=0, y=0.

Verification
REQ-036 Defaults, reset then en=1 held: sof SHALL recur every 420000 cycles; de SHALL be high for 640 consecutive cycles per line on 480 lines; frame_cnt SHALL be 1 after the first full frame.
REQ-037 Defaults, hsync: it SHALL fall 656 cycles after the line's first de cycle and stay low 96 cycles; vsync SHALL be low for exactly 2×800 cycles per frame, starting at line 490.
REQ-038 en toggled 0 for 37 cycles mid-line at x=100: de SHALL be 0 and x SHALL hold 100; after en returns, x SHALL resume at 101, and the total frame period SHALL be 420037 cycles.
REQ-039 resync pulsed at (x=300, y=200): within 2 cycles sof=1 and x=y=0; frame_cnt SHALL be unchanged; a resync coincident with the last frame cycle SHALL leave frame_cnt unchanged.
REQ-040 FW=2, run 5 frames: frame_cnt SHALL read 1,2,3,0,1.
REQ-041 Small parameters (H 4/1/1/1, V 3/1/1/1, HS_POL=1), with reset asserted mid-frame: every output SHALL reach its reset value in 1 cycle; the waveform SHALL be checked cycle-by-cycle against a reference model.
